// File: rtl/sa_result_drain_pkg.sv
// Shared definitions for the systolic-array result drain: project-wide array sizing
// defaults and the serialiser state encoding.
`ifndef PE_ROW
`define PE_ROW 4
`endif
`ifndef PE_COL
`define PE_COL 4
`endif
`ifndef RD_WORD_W
`define RD_WORD_W 32
`endif
`ifndef RD_DEPTH
`define RD_DEPTH 4
`endif

package sa_result_drain_pkg;

  localparam int WORD_W = `RD_WORD_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } drain_st_e;

  // Index width that stays legal for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_vec_fifo.sv
// Circular vector FIFO with combinational head read.
// A push into a full FIFO is taken only when the head pops on the same edge.
module sa_vec_fifo
  import sa_result_drain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = idx_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    lvl_q;
  logic             do_push, do_pop;

  assign full_o  = (lvl_q == LW'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q];
  assign level_o = lvl_q;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/sa_result_drain.sv
// Tracks issued ops through the array latency, captures the row-result vector,
// buffers it and streams it out one word per handshake.
module sa_result_drain
  import sa_result_drain_pkg::*;
#(
  parameter int PE_ROW  = `PE_ROW,
  parameter int LATENCY = `PE_COL,
  parameter int DEPTH   = `RD_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PE_ROW*WORD_W-1:0]  result,
  output logic [WORD_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  input  logic                      ovf_clr,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      busy
);

  localparam int WI_W  = idx_w(PE_ROW);
  localparam int VEC_W = PE_ROW * WORD_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [LATENCY-1:0] tag_q, tag_d;
  logic               cap;
  drain_st_e          state_q, state_d;
  logic [WI_W-1:0]    widx_q, widx_d;
  logic               ovf_q, ovf_d;
  logic               hs, last_word, pop, push, accept;
  logic               fifo_full, fifo_empty;
  logic [LVL_W-1:0]   lvl;
  logic [VEC_W-1:0]   head_vec;
  logic [WORD_W-1:0]  words [PE_ROW];

  // Tag pipe: one bit per cycle of array latency; the top bit marks capture.
  if (LATENCY == 1) begin : g_tag1
    assign tag_d = start;
  end else begin : g_tagn
    assign tag_d = {tag_q[LATENCY-2:0], start};
  end
  assign cap = tag_q[LATENCY-1];

  sa_vec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (VEC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (result),
    .pop_i   (pop),
    .rdata_o (head_vec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (lvl)
  );

  for (genvar r = 0; r < PE_ROW; r++) begin : g_words
    assign words[r] = head_vec[r*WORD_W +: WORD_W];
  end

  assign out_valid = (state_q == S_DRAIN);
  assign last_word = (widx_q == WI_W'(PE_ROW - 1));
  assign hs        = out_valid & out_ready;
  assign pop       = hs & last_word;
  // A full FIFO still takes the capture when its head retires on the same edge.
  assign accept    = ~fifo_full | pop;
  assign push      = cap & accept;

  assign out_last  = out_valid & last_word;
  assign out_data  = out_valid ? words[widx_q] : '0;
  assign overflow  = ovf_q;
  assign level     = lvl;
  assign busy      = (|tag_q) | ~fifo_empty;

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    unique case (state_q)
      S_IDLE: begin
        if (push) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (hs) widx_d = last_word ? '0 : widx_q + 1'b1;
        if (pop && !push && lvl == LVL_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A drop on this edge outranks a clear request.
  always_comb begin
    ovf_d = ovf_q;
    if (cap && !accept) ovf_d = 1'b1;
    else if (ovf_clr)   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q   <= '0;
      state_q <= S_IDLE;
      widx_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      state_q <= state_d;
      widx_q  <= widx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: a per-cycle table for a single op, directed corner
// sequences, and a randomized run, all checked against a queue-based reference model.
module tb_sa_result_drain;

  localparam int PE_ROW = 4;
  localparam int LAT    = 4;
  localparam int DEPTH  = 4;
  localparam int VW     = PE_ROW * 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [VW-1:0] result = '0;
  logic [31:0]   out_data;
  logic          out_valid, out_last, overflow, busy;
  logic [2:0]    level;

  int total = 0;
  int bad   = 0;
  int hs_seen = 0;

  always #5 clk = ~clk;

  sa_result_drain #(.PE_ROW(PE_ROW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .result(result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .ovf_clr(ovf_clr), .overflow(overflow), .level(level), .busy(busy)
  );

  // Reference model: ops in flight are the edge numbers on which they capture;
  // the FIFO is a queue of whole vectors; widx is the word currently offered.
  int            inflight[$];
  logic [VW-1:0] mq[$];
  int            widx = 0;
  bit            movf = 1'b0;
  int            edge_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (edge %0d): got %h expected %h", nm, edge_n, act, exp);
    end
  endtask

  function automatic logic [31:0] m_data();
    logic [VW-1:0] v;
    if (mq.size() == 0) return 32'h0;
    v = mq[0];
    return v[widx*32 +: 32];
  endfunction

  task automatic model_clear();
    inflight.delete();
    mq.delete();
    widx = 0;
    movf = 1'b0;
  endtask

  // Called at a negedge with inputs already applied: check, advance one edge.
  task automatic step();
    bit mv, ml, hs, cap, drop;
    mv = (mq.size() != 0);
    ml = mv && (widx == PE_ROW - 1);
    chk("m_valid", out_valid, mv);
    chk("m_data",  out_data,  m_data());
    chk("m_last",  out_last,  ml);
    chk("m_level", level,     mq.size());
    chk("m_ovf",   overflow,  movf);
    chk("m_busy",  busy,      (inflight.size() != 0) || mv);
    if (out_valid && out_ready) hs_seen++;
    hs = mv && out_ready;
    @(posedge clk);
    edge_n++;
    cap  = (inflight.size() != 0) && (inflight[0] == edge_n);
    if (cap) void'(inflight.pop_front());
    drop = cap && !((mq.size() < DEPTH) || (hs && ml));
    if (drop) movf = 1'b1;
    else if (ovf_clr) movf = 1'b0;
    if (hs) begin
      if (ml) begin
        void'(mq.pop_front());
        widx = 0;
      end else widx++;
    end
    if (cap && !drop) mq.push_back(result);
    if (start) inflight.push_back(edge_n + LAT);
    @(negedge clk);
  endtask

  task automatic cyc(input bit st, input bit rdy, input bit clr);
    start     = st;
    out_ready = rdy;
    ovf_clr   = clr;
    result    = {$urandom, $urandom, $urandom, $urandom};
    step();
  endtask

  typedef struct {
    bit          st;
    bit          hold;
    bit          ev;
    logic [31:0] ed;
    bit          el;
    int          elvl;
    bit          eb;
  } row_t;

  function automatic row_t mk(bit st, bit hold, bit ev, logic [31:0] ed, bit el, int elvl, bit eb);
    row_t r;
    r.st = st; r.hold = hold; r.ev = ev; r.ed = ed; r.el = el; r.elvl = elvl; r.eb = eb;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t          tbl[10];
    logic [VW-1:0] vsingle;
    logic [31:0]   w1;
    int            n, t0;

    // Word r sits at result[r*32 +: 32]; words read out as 1,2,3,4.
    vsingle = {32'd4, 32'd3, 32'd2, 32'd1};
    tbl[0] = mk(1, 0, 0, 32'd0, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 32'd0, 0, 0, 1);
    tbl[2] = mk(0, 0, 0, 32'd0, 0, 0, 1);
    tbl[3] = mk(0, 1, 0, 32'd0, 0, 0, 1);
    tbl[4] = mk(0, 1, 0, 32'd0, 0, 0, 1);
    tbl[5] = mk(0, 1, 1, 32'd1, 0, 1, 1);
    tbl[6] = mk(0, 0, 1, 32'd2, 0, 1, 1);
    tbl[7] = mk(0, 0, 1, 32'd3, 0, 1, 1);
    tbl[8] = mk(0, 0, 1, 32'd4, 1, 1, 1);
    tbl[9] = mk(0, 0, 0, 32'd0, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_last",  out_last,  0);
    chk("rst_level", level,     0);
    chk("rst_ovf",   overflow,  0);
    chk("rst_busy",  busy,      0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    edge_n++;

    // Single op, table-driven per cycle
    for (int c = 0; c < 10; c++) begin
      start     = tbl[c].st;
      out_ready = 1'b1;
      ovf_clr   = 1'b0;
      result    = tbl[c].hold ? vsingle : '0;
      chk($sformatf("tbl%0d_valid", c), out_valid, tbl[c].ev);
      chk($sformatf("tbl%0d_data", c),  out_data,  tbl[c].ed);
      chk($sformatf("tbl%0d_last", c),  out_last,  tbl[c].el);
      chk($sformatf("tbl%0d_level", c), level,     tbl[c].elvl);
      chk($sformatf("tbl%0d_busy", c),  busy,      tbl[c].eb);
      step();
    end

    // Back-to-back: three ops, twelve words with no bubbles
    hs_seen = 0;
    n = 0; t0 = -1;
    for (int i = 0; i < 24; i++) begin
      if (out_valid) begin
        if (t0 < 0) t0 = i;
        n = i;
      end
      cyc(i < 3, 1'b1, 1'b0);
    end
    chk("b2b_words", hs_seen, 12);
    chk("b2b_span",  n - t0,  11);

    // Backpressure on word 1
    cyc(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 20 && !(mq.size() != 0 && widx == 1); k++) cyc(1'b0, 1'b1, 1'b0);
    chk("bp_reach_w1", widx, 1);
    w1 = m_data();
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold_data",  out_data, w1);
      chk("bp_hold_level", level,    1);
      cyc(1'b0, 1'b0, 1'b0);
    end
    repeat (8) cyc(1'b0, 1'b1, 1'b0);

    // Overflow with ready low, then clear
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    chk("ovf_level", level,    4);
    chk("ovf_set",   overflow, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("ovf_clr", overflow, 0);

    // Capture on the same edge as the last-word handshake of a full FIFO
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("simul_full", level,    4);
    chk("simul_last", out_last, 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("simul_level", level,    4);
    chk("simul_ovf",   overflow, 0);
    repeat (20) cyc(1'b0, 1'b1, 1'b0);

    // Asynchronous reset with two ops in flight and one vector draining
    cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("mid_valid_before", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level,     0);
    chk("mid_rst_busy",  busy,      0);
    model_clear();
    @(negedge clk);
    edge_n++;
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) n++;
      cyc(1'b0, 1'b1, 1'b0);
    end
    chk("mid_no_capture", n, 0);

    // Wrap-around: nine ops spaced for continuous draining
    hs_seen = 0;
    repeat (9) begin
      cyc(1'b1, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
    end
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    chk("wrap_words", hs_seen,  36);
    chk("wrap_ovf",   overflow, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
    repeat (40) cyc(1'b0, 1'b1, 1'b0);
    chk("end_idle_busy",  busy,  0);
    chk("end_idle_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
